// File: rtl/pbuf_load_sched_pkg.sv
// Shared types for the parameter-buffer load scheduler: packed command and FSM states.
package pbuf_load_sched_pkg;

  localparam int PE_NUM_DEF = 32;

  typedef struct packed {
    logic [PE_NUM_DEF-1:0] mask;
    logic                  depool;
    logic [1:0]            row_num;
    logic [3:0]            pix_num;
    logic [3:0]            ch_num;
    logic [3:0]            mode;
    logic [7:0]            trans_num;
  } load_cmd_t;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_ACK, S_RUN, S_RETIRE, S_ERR
  } sched_state_e;

endpackage

// File: rtl/pbuf_load_sched_fifo.sv
// Synchronous FIFO with combinational head read and full/empty flags; flush wins over push/pop.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push, w_pop;

  assign full   = (r_cnt == (AW+1)'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign w_push = push && !full && !flush;
  assign w_pop  = pop && !empty && !flush;
  assign dout   = r_mem[r_rp];

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= din;
  end
endmodule

// File: rtl/pbuf_load_sched.sv
// Load command sequencer: queues commands, issues them to the loader one at a time,
// holds configuration for the whole transfer and retires in order, with a RUN watchdog.
module pbuf_load_sched
  import pbuf_load_sched_pkg::*;
#(
  parameter int PE_NUM    = 32,
  parameter int CMD_DEPTH = 4,
  parameter int WDOG_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_trans_num,
  input  logic [3:0]        cmd_mode,
  input  logic [3:0]        cmd_ch_num,
  input  logic [3:0]        cmd_pix_num,
  input  logic [1:0]        cmd_row_num,
  input  logic              cmd_depool,
  input  logic [PE_NUM-1:0] cmd_mask,
  input  logic              flush,
  input  logic [WDOG_W-1:0] wdog_lim,
  output logic              ld_start,
  input  logic              ld_done,
  output logic [7:0]        ld_trans_num,
  output logic [3:0]        ld_mode,
  output logic [3:0]        ld_ch_num,
  output logic [3:0]        ld_pix_num,
  output logic [1:0]        ld_row_num,
  output logic              ld_depool,
  output logic [PE_NUM-1:0] ld_mask,
  output logic              busy,
  output logic              cmd_retire,
  output logic [15:0]       retire_cnt,
  output logic              err_timeout
);
  sched_state_e r_state, w_nxt;
  load_cmd_t    w_cmd_in, w_cmd_out;
  logic         w_full, w_empty, w_pop;
  logic         r_ld_start, r_retire, r_err, r_ack_cnt;
  logic [15:0]  r_retire_cnt;
  logic [WDOG_W-1:0] r_wdog, w_wdog_inc;
  load_cmd_t    r_cfg;

  always_comb begin
    w_cmd_in           = '0;
    w_cmd_in.trans_num = cmd_trans_num;
    w_cmd_in.mode      = cmd_mode;
    w_cmd_in.ch_num    = cmd_ch_num;
    w_cmd_in.pix_num   = cmd_pix_num;
    w_cmd_in.row_num   = cmd_row_num;
    w_cmd_in.depool    = cmd_depool;
    w_cmd_in.mask      = PE_NUM_DEF'(cmd_mask);
  end

  sync_fifo #(.W($bits(load_cmd_t)), .DEPTH(CMD_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .flush(flush),
    .push(cmd_valid), .pop(w_pop), .din(w_cmd_in), .dout(w_cmd_out),
    .full(w_full), .empty(w_empty)
  );

  assign w_wdog_inc = r_wdog + WDOG_W'(1);

  always_comb begin
    w_nxt = r_state;
    w_pop = 1'b0;
    case (r_state)
      S_IDLE:   if (!w_empty) begin w_pop = 1'b1; w_nxt = S_ISSUE; end
      S_ISSUE:  w_nxt = S_ACK;
      // A loader that never drops done is treated as a zero-length transfer.
      S_ACK:    if (!ld_done) w_nxt = S_RUN;
                else if (r_ack_cnt) w_nxt = S_RETIRE;
      S_RUN:    if (ld_done) w_nxt = S_RETIRE;
                else if (wdog_lim != '0 && w_wdog_inc == wdog_lim) w_nxt = S_ERR;
      S_RETIRE: w_nxt = S_IDLE;
      S_ERR:    w_nxt = S_ERR;
      default:  w_nxt = S_IDLE;
    endcase
    if (flush) begin
      w_nxt = S_IDLE;
      w_pop = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_ld_start   <= 1'b0;
      r_retire     <= 1'b0;
      r_retire_cnt <= '0;
      r_err        <= 1'b0;
      r_ack_cnt    <= 1'b0;
      r_wdog       <= '0;
      r_cfg        <= '0;
    end else begin
      r_state    <= w_nxt;
      r_ld_start <= (w_nxt == S_ISSUE);
      r_retire   <= (w_nxt == S_RETIRE);
      if (w_nxt == S_RETIRE) r_retire_cnt <= r_retire_cnt + 16'd1;
      r_ack_cnt  <= (r_state == S_ACK) && (w_nxt == S_ACK);
      r_wdog     <= (r_state == S_RUN && w_nxt == S_RUN) ? w_wdog_inc : '0;
      if (flush) r_err <= 1'b0;
      else if (r_state == S_RUN && w_nxt == S_ERR) r_err <= 1'b1;
      if (w_pop) r_cfg <= w_cmd_out;
    end
  end

  assign cmd_ready    = !w_full;
  assign busy         = (r_state != S_IDLE) || !w_empty;
  assign ld_start     = r_ld_start;
  assign cmd_retire   = r_retire;
  assign retire_cnt   = r_retire_cnt;
  assign err_timeout  = r_err;
  assign ld_trans_num = r_cfg.trans_num;
  assign ld_mode      = r_cfg.mode;
  assign ld_ch_num    = r_cfg.ch_num;
  assign ld_pix_num   = r_cfg.pix_num;
  assign ld_row_num   = r_cfg.row_num;
  assign ld_depool    = r_cfg.depool;
  assign ld_mask      = PE_NUM'(r_cfg.mask);
endmodule

// File: tb/tb_pbuf_load_sched.sv
// Directed bench for pbuf_load_sched with a behavioural loader model driving ld_done.
module tb_pbuf_load_sched;
  localparam int PE = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [7:0]    cmd_trans_num = '0;
  logic [3:0]    cmd_mode = '0, cmd_ch_num = '0, cmd_pix_num = '0;
  logic [1:0]    cmd_row_num = '0;
  logic          cmd_depool = 1'b0;
  logic [PE-1:0] cmd_mask = '0;
  logic          flush = 1'b0;
  logic [15:0]   wdog_lim = '0;
  logic          ld_start;
  logic          ld_done = 1'b1;
  logic [7:0]    ld_trans_num;
  logic [3:0]    ld_mode, ld_ch_num, ld_pix_num;
  logic [1:0]    ld_row_num;
  logic          ld_depool;
  logic [PE-1:0] ld_mask;
  logic          busy, cmd_retire, err_timeout;
  logic [15:0]   retire_cnt;

  int checks = 0;
  int errors = 0;
  int lm_mode = 0;   // 0 normal, 1 hang (never raise done), 2 stuck at done=1
  int lm_len  = 16;
  int lm_cnt  = 0;
  bit chk_start = 1'b0;
  int start_viol = 0;

  always #5 clk = ~clk;

  pbuf_load_sched #(.PE_NUM(PE), .CMD_DEPTH(4), .WDOG_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_trans_num(cmd_trans_num), .cmd_mode(cmd_mode), .cmd_ch_num(cmd_ch_num),
    .cmd_pix_num(cmd_pix_num), .cmd_row_num(cmd_row_num), .cmd_depool(cmd_depool),
    .cmd_mask(cmd_mask), .flush(flush), .wdog_lim(wdog_lim), .ld_start(ld_start),
    .ld_done(ld_done), .ld_trans_num(ld_trans_num), .ld_mode(ld_mode),
    .ld_ch_num(ld_ch_num), .ld_pix_num(ld_pix_num), .ld_row_num(ld_row_num),
    .ld_depool(ld_depool), .ld_mask(ld_mask), .busy(busy), .cmd_retire(cmd_retire),
    .retire_cnt(retire_cnt), .err_timeout(err_timeout)
  );

  // Loader: done drops the cycle after start and stays low for lm_len cycles.
  always @(posedge clk) begin
    if (lm_mode == 2) ld_done <= 1'b1;
    else if (ld_start) begin
      ld_done <= 1'b0;
      lm_cnt  <= lm_len - 1;
    end else if (!ld_done) begin
      if (lm_cnt != 0) lm_cnt <= lm_cnt - 1;
      else if (lm_mode == 0) ld_done <= 1'b1;
    end
  end

  always @(posedge clk) if (chk_start && ld_start && !ld_done) start_viol++;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] tn, input logic [PE-1:0] m);
    cmd_valid = 1'b1; cmd_trans_num = tn; cmd_mask = m; cmd_mode = tn[3:0];
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; step(); step(); rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; step(); step();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (ld_start !== 1'b0 || cmd_retire !== 1'b0 || err_timeout !== 1'b0) begin errors++;
      $display("FAIL reset_pulses got start=%0b retire=%0b err=%0b exp 0", ld_start, cmd_retire, err_timeout); end
    checks++; if (retire_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", retire_cnt); end
    checks++; if ({ld_trans_num, ld_mode, ld_ch_num, ld_pix_num, ld_row_num, ld_depool, ld_mask} !== '0) begin errors++;
      $display("FAIL reset_cfg got trans=%0d mask=%h exp 0", ld_trans_num, ld_mask); end
    rst = 1'b1;
  endtask

  task automatic test_single();
    int ret_idx, n_ret, n_start;
    bit stable;
    do_reset(); lm_mode = 0; lm_len = 16;
    push(8'd15, 32'h0000_000F);
    checks++; if (ld_start !== 1'b0 || busy !== 1'b1) begin errors++;
      $display("FAIL single_t0 got start=%0b busy=%0b exp 0/1", ld_start, busy); end
    step();
    checks++; if (ld_start !== 1'b1) begin errors++; $display("FAIL single_start got %0b exp 1", ld_start); end
    checks++; if (ld_trans_num !== 8'd15 || ld_mask !== 32'h0000_000F) begin errors++;
      $display("FAIL single_cfg got trans=%0d mask=%h exp 15/0000000f", ld_trans_num, ld_mask); end
    ret_idx = -1; n_ret = 0; n_start = 0; stable = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (ld_trans_num !== 8'd15) stable = 1'b0;
      if (ld_start) n_start++;
      if (cmd_retire) begin n_ret++; if (ret_idx < 0) ret_idx = i; end
    end
    checks++; if (ret_idx != 18) begin errors++; $display("FAIL single_retire_time got %0d exp 18", ret_idx); end
    checks++; if (n_ret != 1 || n_start != 0) begin errors++;
      $display("FAIL single_pulses got retire=%0d start=%0d exp 1/0", n_ret, n_start); end
    checks++; if (!stable) begin errors++; $display("FAIL single_stable got unstable exp 15"); end
    checks++; if (retire_cnt !== 16'd1 || busy !== 1'b0) begin errors++;
      $display("FAIL single_end got cnt=%0d busy=%0b exp 1/0", retire_cnt, busy); end
  endtask

  task automatic test_back_to_back();
    int k;
    do_reset(); lm_mode = 0; lm_len = 20; start_viol = 0; chk_start = 1'b1;
    for (int i = 0; i < 5; i++) push(8'(10 + i), 32'h1 << i);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got ready=%0b exp 0", cmd_ready); end
    k = 0;
    for (int c = 0; c < 400 && k < 5; c++) begin
      step();
      if (cmd_retire) begin
        checks++; if (ld_trans_num !== 8'(10 + k)) begin errors++;
          $display("FAIL b2b_order got %0d exp %0d", ld_trans_num, 10 + k); end
        k++;
      end
    end
    step(); step();
    chk_start = 1'b0;
    checks++; if (k != 5) begin errors++; $display("FAIL b2b_timeout got %0d retires exp 5", k); end
    checks++; if (retire_cnt !== 16'd5 || busy !== 1'b0) begin errors++;
      $display("FAIL b2b_end got cnt=%0d busy=%0b exp 5/0", retire_cnt, busy); end
    checks++; if (start_viol != 0) begin errors++; $display("FAIL b2b_start_busy got %0d exp 0", start_viol); end
  endtask

  task automatic test_watchdog();
    int n_start;
    do_reset(); lm_mode = 1; lm_len = 4; wdog_lim = 16'd100;
    push(8'd7, 32'h1);
    step();
    checks++; if (ld_start !== 1'b1) begin errors++; $display("FAIL wdog_start got %0b exp 1", ld_start); end
    step(); step();
    push(8'd8, 32'h2);
    for (int i = 0; i < 98; i++) step();
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL wdog_early got %0b exp 0", err_timeout); end
    step();
    checks++; if (err_timeout !== 1'b1 || busy !== 1'b1) begin errors++;
      $display("FAIL wdog_fire got err=%0b busy=%0b exp 1/1", err_timeout, busy); end
    n_start = 0;
    for (int i = 0; i < 10; i++) begin step(); if (ld_start) n_start++; end
    checks++; if (n_start != 0 || err_timeout !== 1'b1) begin errors++;
      $display("FAIL wdog_hold got starts=%0d err=%0b exp 0/1", n_start, err_timeout); end
    flush = 1'b1; step(); flush = 1'b0;
    checks++; if (err_timeout !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++;
      $display("FAIL wdog_flush got err=%0b busy=%0b ready=%0b exp 0/0/1", err_timeout, busy, cmd_ready); end
    step();
    checks++; if (ld_start !== 1'b0 || retire_cnt !== 16'd0) begin errors++;
      $display("FAIL wdog_after got start=%0b cnt=%0d exp 0/0", ld_start, retire_cnt); end
    wdog_lim = '0; lm_mode = 0; step(); step();
  endtask

  task automatic test_stuck_done();
    do_reset(); lm_mode = 2;
    push(8'd1, 32'h1); push(8'd2, 32'h2);
    checks++; if (ld_start !== 1'b1 || ld_trans_num !== 8'd1) begin errors++;
      $display("FAIL stuck_start1 got start=%0b trans=%0d exp 1/1", ld_start, ld_trans_num); end
    step(); step(); step();
    checks++; if (cmd_retire !== 1'b1 || retire_cnt !== 16'd1) begin errors++;
      $display("FAIL stuck_retire1 got retire=%0b cnt=%0d exp 1/1", cmd_retire, retire_cnt); end
    step(); step();
    checks++; if (ld_start !== 1'b1 || ld_trans_num !== 8'd2) begin errors++;
      $display("FAIL stuck_start2 got start=%0b trans=%0d exp 1/2", ld_start, ld_trans_num); end
    step(); step(); step();
    checks++; if (cmd_retire !== 1'b1 || retire_cnt !== 16'd2) begin errors++;
      $display("FAIL stuck_retire2 got retire=%0b cnt=%0d exp 1/2", cmd_retire, retire_cnt); end
    lm_mode = 0;
  endtask

  task automatic test_reset_mid_run();
    int n_start;
    do_reset(); lm_mode = 0; lm_len = 20;
    push(8'd1, 32'h1); push(8'd2, 32'h2); push(8'd3, 32'h4);
    step(); step();
    rst = 1'b0; step(); rst = 1'b1;
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || ld_start !== 1'b0 || cmd_retire !== 1'b0) begin errors++;
      $display("FAIL rstrun_flags got busy=%0b ready=%0b start=%0b retire=%0b exp 0/1/0/0", busy, cmd_ready, ld_start, cmd_retire); end
    checks++; if (ld_trans_num !== 8'd0 || ld_mask !== '0 || retire_cnt !== 16'd0 || err_timeout !== 1'b0) begin errors++;
      $display("FAIL rstrun_vals got trans=%0d mask=%h cnt=%0d exp 0", ld_trans_num, ld_mask, retire_cnt); end
    n_start = 0;
    for (int i = 0; i < 30; i++) begin step(); if (ld_start) n_start++; end
    checks++; if (n_start != 0) begin errors++; $display("FAIL rstrun_idle got %0d starts exp 0", n_start); end
    push(8'd9, 32'h8); step();
    checks++; if (ld_start !== 1'b1 || ld_trans_num !== 8'd9) begin errors++;
      $display("FAIL rstrun_new got start=%0b trans=%0d exp 1/9", ld_start, ld_trans_num); end
  endtask

  task automatic test_flush_coincident();
    int n_act;
    do_reset(); lm_mode = 0; lm_len = 4;
    push(8'd5, 32'h1);
    for (int i = 0; i < 15; i++) step();
    checks++; if (retire_cnt !== 16'd1) begin errors++; $display("FAIL flush_pre got %0d exp 1", retire_cnt); end
    push(8'd6, 32'h2); push(8'd7, 32'h4);
    cmd_valid = 1'b1; cmd_trans_num = 8'd8; flush = 1'b1;
    step();
    cmd_valid = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || ld_start !== 1'b0) begin errors++;
      $display("FAIL flush_state got busy=%0b ready=%0b start=%0b exp 0/1/0", busy, cmd_ready, ld_start); end
    checks++; if (retire_cnt !== 16'd1) begin errors++; $display("FAIL flush_cnt got %0d exp 1", retire_cnt); end
    n_act = 0;
    for (int i = 0; i < 10; i++) begin step(); if (ld_start || cmd_retire || busy) n_act++; end
    checks++; if (n_act != 0) begin errors++; $display("FAIL flush_quiet got %0d active cycles exp 0", n_act); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_watchdog();
    test_stuck_done();
    test_reset_mid_run();
    test_flush_coincident();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pbuf_load_sched.md
# pbuf_load_sched

Command sequencer for the parameter-buffer loader. Accepts queued load commands from the layer controller into a small FIFO and drives the loader's start/configuration interface. Holds each command's configuration stable for the whole transfer, waits on the loader's done level, and retires commands in order. A watchdog flags a stalled transfer.

## Interface
Parameters:
- `PE_NUM`, 32, number of PEs; width of the write-mask field.
- `CMD_DEPTH`, 4, command FIFO depth; power of two, at least 2.
- `WDOG_W`, 16, watchdog counter width.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-low reset.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake; a transfer occurs when both are 1 at a rising edge.
- `cmd_trans_num` in 8, `cmd_mode` in 4, `cmd_ch_num` in 4, `cmd_pix_num` in 4, `cmd_row_num` in 2, `cmd_depool` in 1, `cmd_mask` in PE_NUM: command fields.
- `flush` in 1: drop all queued commands and abort tracking.
- `wdog_lim` in WDOG_W: watchdog limit; 0 disables the watchdog.
- `ld_start` out 1: one-cycle start pulse to the loader.
- `ld_done` in 1: loader done level; high when idle, low while busy.
- `ld_trans_num`, `ld_mode`, `ld_ch_num`, `ld_pix_num`, `ld_row_num`, `ld_depool`, `ld_mask` out: registered configuration, same widths as the command fields.
- `busy` out 1: FSM not in IDLE, or FIFO not empty.
- `cmd_retire` out 1: one-cycle pulse per completed command.
- `retire_cnt` out 16: number of retired commands; wraps.
- `err_timeout` out 1: sticky watchdog error.

## Operation
- FIFO of CMD_DEPTH entries holds the packed command; `cmd_ready` = FIFO not full.
- FSM states are IDLE, ISSUE, ACK, RUN, RETIRE, ERR.
- IDLE: if the FIFO is non-empty, pop it, register all `ld_*` fields, go to ISSUE.
- ISSUE: `ld_start`=1 for this cycle only; go to ACK.
- ACK: if `ld_done`=0, go to RUN. If `ld_done`=1, stay in ACK for at most 2 cycles. After that, treat the transfer as a zero-length completion and go to RETIRE.
- RUN: when `ld_done`=1, go to RETIRE. The watchdog increments each cycle in RUN. If `wdog_lim`≠0 and the count equals `wdog_lim`, set `err_timeout` and go to ERR.
- RETIRE: `cmd_retire`=1 for this cycle and `retire_cnt`+1; go to IDLE.
- ERR: `ld_start` is never asserted. The FSM leaves ERR only via `flush` or reset.
- `ld_*` fields change only in IDLE on a pop. They are stable from ISSUE through RETIRE.
- `flush`, from any state, takes priority over every other transition:
  - empties the FIFO and returns to IDLE;
  - clears `err_timeout` and the watchdog;
  - drops a `cmd_valid` accepted in the same cycle;
  - does not change `retire_cnt`.
- Simultaneous push and pop on a full FIFO are not possible, because `cmd_ready`=0 when full. On a non-full FIFO, simultaneous push and pop are both honoured.

## Timing
- Reset values (`rst`=0 at a clock edge):
  - FSM IDLE, FIFO empty, `cmd_ready`=1;
  - `ld_start`=0, all `ld_*`=0, `busy`=0;
  - `cmd_retire`=0, `retire_cnt`=0, `err_timeout`=0, watchdog=0.
- A reset during a transfer aborts tracking; the loader is not notified.
- Latency: a command accepted at edge t into an empty FIFO with the FSM in IDLE is popped at edge t+1, and `ld_start` is high in cycle t+2.
- `cmd_retire` is high in the cycle after the first cycle in RUN where `ld_done`=1.
- Minimum command-to-command spacing is 5 cycles (IDLE, ISSUE, ACK, RUN, RETIRE). The next `ld_start` comes 2 cycles after RETIRE if the FIFO is non-empty.
- All outputs are registered except `cmd_ready` and `busy`.

## Structure
- Shared package: the `load_cmd_t` packed struct (all command fields) and the state enum `sched_state_e`.
- Sub-module: `sync_fifo`, parameterized by width and depth, with full/empty flags. The scheduler instantiates it with width `$bits(load_cmd_t)`.

## Test plan
- Single command: trans_num=15, mask=32'h0000_000F; loader model drops done 1 cycle after start and raises it 16 cycles later. Required: `ld_start` at t+2, `ld_trans_num`=15 stable throughout, exactly one `cmd_retire`, `retire_cnt`=1.
- Back-to-back: push 5 commands with CMD_DEPTH=4. Required: `cmd_ready`=0 after 4 queued with none popped; commands retire in push order; `retire_cnt`=5; no start pulse while `ld_done`=0.
- Watchdog: `wdog_lim`=100 and the loader never raises done. Required: `err_timeout`=1 after 100 cycles in RUN and no further `ld_start`. Then `flush` → IDLE, `err_timeout`=0, FIFO empty.
- Non-responding loader: `ld_done` stuck at 1. Required: ACK times out after 2 cycles, RETIRE pulses, next command issues.
- Reset mid-RUN with 2 queued commands: required all reset values, `busy`=0, no `ld_start` until a new push.
- Flush coincident with `cmd_valid`: required the command is dropped, FIFO empty, `retire_cnt` unchanged.
